// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int ROUND_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MIX   = 3'd2,
        CAP   = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Round constants for key expansion; entry i belongs to round i+1.
    localparam logic [7:0] RCON_TAB [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_rcon_rom.sv
// Round-index to Rcon lookup, forced to zero whenever no key step is issued.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   round_idx_i  round currently being computed (1..10 are valid rounds)
//   key_en_i     key register advances this cycle
//   rcon_o       round constant for this key step, 8'h00 otherwise
module aes_rcon_rom
    import aes_pkg::*;
(
    input  logic [ROUND_W-1:0] round_idx_i,
    input  logic               key_en_i,
    output logic [7:0]         rcon_o
);

    logic [ROUND_W-1:0] tab_idx;

    assign tab_idx = round_idx_i - ROUND_W'(1);

    always_comb begin
        rcon_o = 8'h00;
        if (key_en_i && (round_idx_i != '0) &&
            (round_idx_i <= ROUND_W'(NUM_ROUNDS))) begin
            rcon_o = RCON_TAB[tab_idx];
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer driving a shared round datapath.
// Latency: first done_valid cycle is 1 + 9*(MIX_LAT+1) + 1 cycles after start accept.
// Backpressure: start_ready only in IDLE; done_valid held until done_ready.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start_valid/start_ready  job request handshake
//   done_valid/done_ready    result handshake
//   ld_state                 load plaintext^key / cipher key
//   st_en, key_en            capture round result / advance key schedule
//   mix_bypass               final round skips mixcolumn
//   round_idx, rcon          current round and its round constant
//   busy                     any state other than IDLE
//   abort                    only with AES_ROUND_CTRL_ABORT_EN defined:
//                            drops the in-flight job from INIT/MIX/CAP/FINAL
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int MIX_LAT    = 1,
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    output logic               done_valid,
    input  logic               done_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               ld_state,
    output logic               st_en,
    output logic               key_en,
    output logic               mix_bypass,
    output logic [ROUND_W-1:0] round_idx,
    output logic [7:0]         rcon,
    output logic               busy
);

    // Last round that still goes through mixcolumn; the one after it is FINAL.
    localparam logic [ROUND_W-1:0] LAST_MIX_ROUND = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] FINAL_ROUND    = ROUND_W'(NUM_ROUNDS);
    // Terminal wait-counter value; unused when MIX_LAT = 0 since MIX is never entered.
    localparam logic [2:0]         MIX_LAST       = (MIX_LAT == 0) ? 3'd0 : 3'(MIX_LAT - 1);
    // With no mixcolumn pipeline, every round goes straight to capture.
    localparam state_e             WAIT_STATE     = (MIX_LAT == 0) ? CAP : MIX;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort && ((state_q == INIT) || (state_q == MIX) ||
                                 (state_q == CAP)  || (state_q == FINAL));
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        cnt_d       = cnt_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        ld_state    = 1'b0;
        st_en       = 1'b0;
        key_en      = 1'b0;
        mix_bypass  = 1'b0;
        busy        = 1'b1;

        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                round_d     = '0;
                if (start_valid) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                ld_state = 1'b1;
                round_d  = ROUND_W'(1);
                cnt_d    = 3'd0;
                state_d  = WAIT_STATE;
            end
            MIX: begin
                // Idle cycles while the registered mixcolumn result settles.
                if (cnt_q == MIX_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CAP: begin
                st_en  = 1'b1;
                key_en = 1'b1;
                if (round_q == LAST_MIX_ROUND) begin
                    round_d = FINAL_ROUND;
                    state_d = FINAL;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                    state_d = WAIT_STATE;
                end
            end
            FINAL: begin
                // Last round has no mixcolumn, so no wait is needed here.
                mix_bypass = 1'b1;
                st_en      = 1'b1;
                key_en     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    round_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
                cnt_d   = 3'd0;
            end
        endcase

        // An aborted cycle must not disturb the datapath registers.
        if (abort_hit) begin
            st_en   = 1'b0;
            key_en  = 1'b0;
            state_d = IDLE;
            round_d = '0;
            cnt_d   = 3'd0;
        end
    end

    assign round_idx = round_q;

    aes_rcon_rom u_rcon_rom (
        .round_idx_i (round_q),
        .key_en_i    (key_en),
        .rcon_o      (rcon)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: MIX_LAT=1 and MIX_LAT=0 instances.
// Latency: n/a.
// Backpressure: done_ready driven directed and random.
module tb_aes_round_ctrl;

    localparam logic [18:0] RESET_VEC = 19'h40000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sv1 = 1'b0, dr1 = 1'b0, ab1 = 1'b0;
    logic sv0 = 1'b0, dr0 = 1'b0, ab0 = 1'b0;

    logic       sr1, dv1, ld1, st1, ke1, by1, bz1;
    logic [3:0] idx1;
    logic [7:0] rc1;
    logic       sr0, dv0, ld0, st0, ke0, by0, bz0;
    logic [3:0] idx0;
    logic [7:0] rc0;
    logic [18:0] obs1, obs0;

    int tests = 0;
    int fails = 0;

    bit m1_bz = 1'b0, m0_bz = 1'b0;
    int m1_pos = 0,   m0_pos = 0;

    always #5 clk = ~clk;

    assign obs1 = {sr1, dv1, ld1, st1, ke1, by1, bz1, idx1, rc1};
    assign obs0 = {sr0, dv0, ld0, st0, ke0, by0, bz0, idx0, rc0};

    aes_round_ctrl #(.MIX_LAT(1), .NUM_ROUNDS(10)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv1),
        .start_ready (sr1),
        .done_valid  (dv1),
        .done_ready  (dr1),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort       (ab1),
`endif
        .ld_state    (ld1),
        .st_en       (st1),
        .key_en      (ke1),
        .mix_bypass  (by1),
        .round_idx   (idx1),
        .rcon        (rc1),
        .busy        (bz1)
    );

    aes_round_ctrl #(.MIX_LAT(0), .NUM_ROUNDS(10)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv0),
        .start_ready (sr0),
        .done_valid  (dv0),
        .done_ready  (dr0),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort       (ab0),
`endif
        .ld_state    (ld0),
        .st_en       (st0),
        .key_en      (ke0),
        .mix_bypass  (by0),
        .round_idx   (idx0),
        .rcon        (rc0),
        .busy        (bz0)
    );

    // AES round constant for round r, by repeated GF(2^8) doubling.
    function automatic logic [7:0] rc_of(input int r);
        logic [7:0] x;
        x = 8'h01;
        for (int i = 1; i < r; i++) begin
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return x;
    endfunction

    // Expected outputs for a job at position pos cycles after its accepting edge.
    // Each round r (1..9) spans L wait cycles followed by one capture cycle.
    function automatic logic [18:0] exp_out(input int L, input bit bz, input int pos, input logic ab);
        logic       sr, dv, ld, st, ke, by;
        logic [3:0] idx;
        logic [7:0] rc;
        int rlen, fin, r, k;
        sr = 1'b0; dv = 1'b0; ld = 1'b0; st = 1'b0; ke = 1'b0; by = 1'b0;
        idx = 4'd0; rc = 8'h00;
        rlen = L + 1;
        fin  = 9 * rlen + 1;
        if (!bz) begin
            sr = 1'b1;
        end else if (pos == 0) begin
            ld = 1'b1;
        end else if (pos < fin) begin
            r   = (pos - 1) / rlen + 1;
            k   = (pos - 1) % rlen;
            idx = 4'(r);
            if (k == L && !ab) begin
                st = 1'b1; ke = 1'b1; rc = rc_of(r);
            end
        end else if (pos == fin) begin
            idx = 4'd10;
            by  = 1'b1;
            if (!ab) begin
                st = 1'b1; ke = 1'b1; rc = rc_of(10);
            end
        end else begin
            dv  = 1'b1;
            idx = 4'd10;
        end
        return {sr, dv, ld, st, ke, by, bz, idx, rc};
    endfunction

    task automatic model_adv(input int L, input bit bz, input int pos,
                             input logic sv, input logic dr, input logic ab,
                             output bit nbz, output int npos);
        int donep;
        donep = 9 * (L + 1) + 2;
        if (!bz) begin
            nbz = sv; npos = 0;
        end else if (pos >= donep) begin
            nbz = !dr; npos = pos;
        end else if (ab) begin
            nbz = 1'b0; npos = 0;
        end else begin
            nbz = 1'b1; npos = pos + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit nb;
        int np;
        @(posedge clk);
        model_adv(1, m1_bz, m1_pos, sv1, dr1, ab1, nb, np);
        m1_bz = nb; m1_pos = np;
        model_adv(0, m0_bz, m0_pos, sv0, dr0, ab0, nb, np);
        m0_bz = nb; m0_pos = np;
        #1;
        chk("cyc_dut1", 32'(obs1), 32'(exp_out(1, m1_bz, m1_pos, ab1)));
        chk("cyc_dut0", 32'(obs0), 32'(exp_out(0, m0_bz, m0_pos, ab0)));
        chk("excl_dut1", 32'(ld1 & (st1 | ke1)), 32'd0);
    endtask

    initial begin
        int n, caps, ld_cnt, cyc, last_done, dv_seen;
        logic [7:0] exp_rc;

        // Reset
        #1 rst_n = 1'b0;
        #2;
        chk("reset_dut1", 32'(obs1), 32'(RESET_VEC));
        chk("reset_dut0", 32'(obs0), 32'(RESET_VEC));
        #5 rst_n = 1'b1;
        step();
        step();

        // Single directed job, MIX_LAT = 1, consumer stalls in DONE
        sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        chk("ld_after_accept", 32'(ld1), 32'd1);
        n = 0; caps = 0; exp_rc = 8'h01;
        while (!dv1 && n < 200) begin
            step();
            n++;
            if (st1 && !by1) begin
                caps++;
                chk("cap_rcon", 32'(rc1), 32'(exp_rc));
                exp_rc = {exp_rc[6:0], 1'b0} ^ (exp_rc[7] ? 8'h1b : 8'h00);
            end
            if (st1 && by1) chk("final_rcon", 32'(rc1), 32'h36);
        end
        chk("latency_l1", 32'(n), 32'(1 + 9 * (1 + 1) + 1));
        chk("cap_count", 32'(caps), 32'd9);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("done_hold", 32'({dv1, idx1}), 32'({1'b1, 4'd10}));
        end
        dr1 = 1'b1;
        step();
        dr1 = 1'b0;
        chk("idle_after_hs", 32'({sr1, bz1}), 32'b10);

        // Back-to-back jobs with start_valid and done_ready held high
        sv1 = 1'b1; dr1 = 1'b1;
        ld_cnt = 0; cyc = 0; last_done = -1;
        while (ld_cnt < 3 && cyc < 300) begin
            step();
            cyc++;
            if (dv1) last_done = cyc;
            if (ld1) begin
                ld_cnt++;
                if (last_done >= 0) chk("b2b_gap", 32'(cyc - last_done), 32'd2);
            end
        end
        chk("b2b_jobs", 32'(ld_cnt), 32'd3);
        sv1 = 1'b0;
        n = 0;
        while (bz1 && n < 100) begin
            step();
            n++;
        end
        dr1 = 1'b0;
        chk("b2b_drain", 32'(bz1), 32'd0);

        // MIX_LAT = 0 instance
        sv0 = 1'b1;
        step();
        sv0 = 1'b0;
        n = 0; caps = 0;
        while (!dv0 && n < 200) begin
            step();
            n++;
            if (st0 && !by0) caps++;
        end
        chk("latency_l0", 32'(n), 32'(1 + 9 * (0 + 1) + 1));
        chk("cap_count_l0", 32'(caps), 32'd9);
        dr0 = 1'b1;
        step();
        dr0 = 1'b0;

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            sv1 = ($urandom_range(0, 3) == 0);
            dr1 = ($urandom_range(0, 2) == 0);
            sv0 = ($urandom_range(0, 3) == 0);
            dr0 = ($urandom_range(0, 2) == 0);
`ifdef AES_ROUND_CTRL_ABORT_EN
            ab1 = ($urandom_range(0, 29) == 0);
            ab0 = ($urandom_range(0, 29) == 0);
`endif
            step();
        end
        sv1 = 1'b0; sv0 = 1'b0; ab1 = 1'b0; ab0 = 1'b0;
        dr1 = 1'b1; dr0 = 1'b1;
        n = 0;
        while ((bz1 || bz0) && n < 100) begin
            step();
            n++;
        end
        dr1 = 1'b0; dr0 = 1'b0;
        chk("rand_drain", 32'({bz1, bz0}), 32'd0);

        // Asynchronous reset in round 5, then a fresh job
        sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        n = 0;
        while (idx1 != 4'd5 && n < 100) begin
            step();
            n++;
        end
        chk("reach_round5", 32'(idx1), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dut1", 32'(obs1), 32'(RESET_VEC));
        chk("async_rst_dut0", 32'(obs0), 32'(RESET_VEC));
        m1_bz = 1'b0; m1_pos = 0;
        m0_bz = 1'b0; m0_pos = 0;
        #1 rst_n = 1'b1;
        step();
        sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        n = 0;
        while (!dv1 && n < 200) begin
            step();
            n++;
        end
        chk("latency_after_rst", 32'(n), 32'(1 + 9 * (1 + 1) + 1));
        dr1 = 1'b1;
        step();
        dr1 = 1'b0;

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort during the wait cycle of round 3
        sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        n = 0;
        while (!(idx1 == 4'd3 && bz1 && !st1) && n < 100) begin
            step();
            n++;
        end
        chk("reach_round3_mix", 32'({idx1, bz1, st1}), 32'({4'd3, 1'b1, 1'b0}));
        ab1 = 1'b1;
        #1;
        chk("abort_no_en", 32'({st1, ke1}), 32'd0);
        step();
        ab1 = 1'b0;
        chk("abort_idle", 32'({sr1, bz1, idx1}), 32'({1'b1, 1'b0, 4'd0}));
        dv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dv1) dv_seen++;
        end
        chk("abort_no_done", 32'(dv_seen), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption round sequencer for a single shared round datapath (SubBytes/ShiftRows, mixcolumn, AddRoundKey, key expansion).
- Accepts a job by valid/ready handshake and drives per-cycle datapath enables, round index and Rcon.
- Waits out the registered mixcolumn latency, bypasses mixcolumn in round 10, and holds a done handshake until the consumer takes the result.

Parameters:
- MIX_LAT, 1, mixcolumn pipeline depth in cycles; legal range 0..7; 0 means the MIX state is skipped.
- NUM_ROUNDS, 10, total AES rounds; fixed at 10 for AES-128.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  job request; plaintext and key are stable on the datapath inputs while this is high.
- start_ready  out  1  high only in IDLE.
- done_valid  out  1  result in the datapath state register is valid.
- done_ready  in  1  consumer accepts the result.
- ld_state  out  1  state register loads plaintext XOR key; key register loads the cipher key.
- st_en  out  1  state register captures the round result.
- key_en  out  1  key register advances one expansion step using rcon.
- mix_bypass  out  1  route ShiftRows output around mixcolumn (final round).
- round_idx  out  4  round being computed, 0..10.
- rcon  out  8  round constant for the current key_en.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0 except start_ready = 1; round_idx = 0; rcon = 8'h00; internal wait counter = 0.
- State machine: IDLE, INIT, MIX, CAP, FINAL, DONE.
- IDLE: start_ready = 1. On start_valid is 1 at a clock edge, go to INIT. start_valid is ignored in every other state, because start_ready = 0 there.
- INIT (1 cycle): ld_state = 1, round_idx = 0. Next state is MIX (or CAP when MIX_LAT = 0), and round_idx becomes 1.
- MIX (MIX_LAT cycles): mix_bypass = 0; the wait counter counts 0..MIX_LAT-1, then the state goes to CAP. No enables are asserted.
- CAP (1 cycle): st_en = 1, key_en = 1, rcon = RCON[round_idx].
  - If round_idx < 9: round_idx increments and the state returns to MIX (or CAP).
  - If round_idx = 9: round_idx becomes 10 and the state goes to FINAL.
- FINAL (1 cycle): mix_bypass = 1, st_en = 1, key_en = 1, rcon = 8'h36. Next state is DONE.
- DONE: done_valid = 1, round_idx holds at 10. done_valid stays high until done_ready = 1 at a clock edge, then the state goes to IDLE.
- done_ready sampled outside DONE has no effect.
- RCON[1..10] = 01 02 04 08 10 20 40 80 1b 36. rcon = 00 whenever key_en = 0.
- Latency: the first DONE cycle is 1 + 9*(MIX_LAT+1) + 1 cycles after the accepting edge, i.e. 20 cycles for MIX_LAT = 1.
- Throughput: at least one IDLE cycle between jobs, so a new job's start_ready rises the cycle after done handshake.
- Asynchronous reset in any state forces the reset values immediately; the in-flight job is lost and no done_valid is produced.
- Enables are mutually exclusive per cycle: ld_state never coincides with st_en or key_en.

Optional Feature:
- Macro: AES_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort = 1 at a clock edge in INIT, MIX, CAP or FINAL returns the state to IDLE next cycle with round_idx = 0. No done_valid is produced and no st_en or key_en is issued in the abort cycle.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package aes_pkg holds:
  - the state enum (IDLE, INIT, MIX, CAP, FINAL, DONE);
  - NUM_ROUNDS = 10;
  - the 10-entry RCON constant table;
  - a ROUND_W = 4 width constant.
- One sub-module, aes_rcon_rom: combinational round_idx to rcon lookup, gated by key_en.
- The FSM and wait counter stay in aes_round_ctrl.

Test Plan:
- Reset, then a single job with MIX_LAT = 1 and start_valid pulsed 1 cycle:
  - ld_state appears 1 cycle after accept;
  - 9 CAP pulses occur every 2 cycles with rcon 01..1b and mix_bypass = 0;
  - FINAL has rcon = 36 and mix_bypass = 1;
  - done_valid rises exactly 20 cycles after accept.
- done_ready held 0 for 5 cycles in DONE: done_valid and round_idx = 10 stay stable; done_ready = 1 returns the block to IDLE with start_ready = 1 next cycle.
- start_valid held high continuously with done_ready = 1: jobs run back-to-back, with exactly one IDLE cycle between DONE and the next INIT.
- MIX_LAT = 0 build: no MIX state; CAP is consecutive every cycle; done_valid arrives 11 cycles after accept.
- rst_n asserted low mid-round (round_idx = 5): outputs reach their reset values asynchronously; after release, a fresh job completes normally.
- AES_ROUND_CTRL_ABORT_EN defined, abort pulsed in round 3 MIX: the block returns to IDLE next cycle, no st_en/key_en in that cycle, and no done_valid.
